// File: rtl/z80_spi_mailbox_if.sv
// Z80 bus strobes/address and SPI byte-engine signals of the mailbox.
// The bidirectional data bus z80_d stays a plain inout port on the top module.
interface z80_spi_mailbox_if;
    logic [15:0] z80_a;
    logic        z80_rd;
    logic        z80_wr;
    logic        z80_iorq;
    logic        z80_mreq;
    logic        z80_m1;
    logic        z80_d_dir;
    logic        z80_int_n;
    logic        spi_cs_n;
    logic        spi_rx_valid;
    logic [7:0]  spi_rx_data;
    logic [7:0]  spi_tx_data;

    // Driven by the Z80 bus model / SPI engine side.
    modport master (
        output z80_a, z80_rd, z80_wr, z80_iorq, z80_mreq, z80_m1,
        output spi_cs_n, spi_rx_valid, spi_rx_data,
        input  z80_d_dir, z80_int_n, spi_tx_data
    );

    // The mailbox itself.
    modport slave (
        input  z80_a, z80_rd, z80_wr, z80_iorq, z80_mreq, z80_m1,
        input  spi_cs_n, spi_rx_valid, spi_rx_data,
        output z80_d_dir, z80_int_n, spi_tx_data
    );
endinterface

// File: rtl/z80_spi_mailbox.sv
// Bank of NUM_REGS bidirectional byte mailboxes between a Z80 I/O window and a
// framed SPI command protocol. Z80 reads are combinational; Z80 writes and
// read-side flag clears are committed through a synchroniser pipeline.
module z80_spi_mailbox #(
    parameter int unsigned NUM_REGS    = 8,
    parameter logic [15:0] BASE_ADDR   = 16'd12345,
    parameter int unsigned ADDR_STRIDE = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [7:0]       z80_d,
    z80_spi_mailbox_if.slave bus
);

    localparam int unsigned PTR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [15:0] STATUS_ADDR = 16'(32'(BASE_ADDR) + NUM_REGS * ADDR_STRIDE);
    localparam logic [15:0] CTRL_ADDR   = 16'(32'(STATUS_ADDR) + ADDR_STRIDE);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWrData,
        StRdData,
        StErr
    } state_t;

    // True when the address selects one of the mailboxes.
    function automatic logic f_mb_hit(input logic [15:0] a);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (a == 16'(32'(BASE_ADDR) + i * ADDR_STRIDE)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Mailbox index selected by the address (0 when no mailbox is hit).
    function automatic logic [PTR_W-1:0] f_mb_idx(input logic [15:0] a);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (a == 16'(32'(BASE_ADDR) + i * ADDR_STRIDE)) begin
                idx = PTR_W'(i);
            end
        end
        return idx;
    endfunction

    // Mailbox pointer increment, wrapping at the last mailbox.
    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Storage and control state.
    logic [7:0]          r_spi_to_z80 [NUM_REGS];
    logic [7:0]          r_z80_to_spi [NUM_REGS];
    logic [NUM_REGS-1:0] r_flags;
    logic [NUM_REGS-1:0] w_flags_d;
    logic                r_irq_en;
    logic                r_int_n;
    state_t              r_state;
    state_t              w_state_d;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    w_ptr_d;
    logic [7:0]          r_tx;
    logic [7:0]          w_tx_d;
    logic                w_spi_wr_en;

    // Synchroniser and matched address/data pipelines.
    logic [SYNC_STAGES-1:0] r_wr_sync;
    logic [SYNC_STAGES-1:0] r_rd_sync;
    logic                   r_wr_prev;
    logic                   r_rd_prev;
    logic [15:0]            r_a_pipe [SYNC_STAGES];
    logic [7:0]             r_d_pipe [SYNC_STAGES];

    logic             w_io;
    logic             w_rd_dec;
    logic             w_wr_dec;
    logic             w_drive;
    logic [7:0]       w_rd_data;
    logic [7:0]       w_flags8;
    logic             w_wr_rise;
    logic             w_rd_rise;
    logic [15:0]      w_a_sync;
    logic [7:0]       w_d_sync;
    logic             w_sync_mb_hit;
    logic [PTR_W-1:0] w_sync_mb_idx;
    logic [6:0]       w_cmd_idx;

    assign w_io     = ~bus.z80_iorq & bus.z80_mreq & bus.z80_m1;
    assign w_rd_dec = w_io & ~bus.z80_rd & bus.z80_wr;
    assign w_wr_dec = w_io & ~bus.z80_wr & bus.z80_rd;

    // Flags zero-extended to a byte for STATUS and the first SPI byte.
    always_comb begin
        w_flags8 = 8'h00;
        w_flags8[NUM_REGS-1:0] = r_flags;
    end

    // Combinational Z80 read mux and bus drive enable.
    always_comb begin
        w_drive   = 1'b0;
        w_rd_data = 8'h00;
        if (w_rd_dec && !rst) begin
            if (f_mb_hit(bus.z80_a)) begin
                w_drive   = 1'b1;
                w_rd_data = r_spi_to_z80[f_mb_idx(bus.z80_a)];
            end else if (bus.z80_a == STATUS_ADDR) begin
                w_drive   = 1'b1;
                w_rd_data = w_flags8;
            end else if (bus.z80_a == CTRL_ADDR) begin
                w_drive   = 1'b1;
                w_rd_data = {7'b0, r_irq_en};
            end
        end
    end

    assign z80_d         = w_drive ? w_rd_data : 8'bz;
    assign bus.z80_d_dir = ~w_drive;

    // Synchronise the decoded strobes; carry address/data alongside at equal depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_sync <= '0;
            r_rd_sync <= '0;
            r_wr_prev <= 1'b0;
            r_rd_prev <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_a_pipe[i] <= '0;
                r_d_pipe[i] <= '0;
            end
        end else begin
            r_wr_sync   <= {r_wr_sync[SYNC_STAGES-2:0], w_wr_dec};
            r_rd_sync   <= {r_rd_sync[SYNC_STAGES-2:0], w_rd_dec};
            r_wr_prev   <= r_wr_sync[SYNC_STAGES-1];
            r_rd_prev   <= r_rd_sync[SYNC_STAGES-1];
            r_a_pipe[0] <= bus.z80_a;
            r_d_pipe[0] <= z80_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_a_pipe[i] <= r_a_pipe[i-1];
                r_d_pipe[i] <= r_d_pipe[i-1];
            end
        end
    end

    assign w_wr_rise     = r_wr_sync[SYNC_STAGES-1] & ~r_wr_prev;
    assign w_rd_rise     = r_rd_sync[SYNC_STAGES-1] & ~r_rd_prev;
    assign w_a_sync      = r_a_pipe[SYNC_STAGES-1];
    assign w_d_sync      = r_d_pipe[SYNC_STAGES-1];
    assign w_sync_mb_hit = f_mb_hit(w_a_sync);
    assign w_sync_mb_idx = f_mb_idx(w_a_sync);

    // Commit Z80 writes to the Z80->SPI mailboxes and the CTRL register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_en <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_z80_to_spi[i] <= 8'h00;
            end
        end else if (w_wr_rise) begin
            if (w_sync_mb_hit) begin
                r_z80_to_spi[w_sync_mb_idx] <= w_d_sync;
            end else if (w_a_sync == CTRL_ADDR) begin
                r_irq_en <= w_d_sync[0];
            end
        end
    end

    // Flag next state: Z80 read clears, SPI write sets, set has priority.
    always_comb begin
        w_flags_d = r_flags;
        if (w_rd_rise && w_sync_mb_hit) begin
            w_flags_d[w_sync_mb_idx] = 1'b0;
        end
        if (w_spi_wr_en) begin
            w_flags_d[r_ptr] = 1'b1;
        end
    end

    // Flags and the registered interrupt output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= '0;
            r_int_n <= 1'b1;
        end else begin
            r_flags <= w_flags_d;
            r_int_n <= ~(r_irq_en & |r_flags);
        end
    end

    assign bus.z80_int_n = r_int_n;

    // SPI frame FSM: next state, pointer, tx byte and mailbox write strobe.
    always_comb begin
        w_state_d   = r_state;
        w_ptr_d     = r_ptr;
        w_tx_d      = r_tx;
        w_spi_wr_en = 1'b0;
        w_cmd_idx   = bus.spi_rx_data[6:0];
        if (bus.spi_cs_n) begin
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_state_d = StCmd;
                    w_tx_d    = w_flags8;
                end
                StCmd: begin
                    if (bus.spi_rx_valid) begin
                        if (32'(w_cmd_idx) >= NUM_REGS) begin
                            w_state_d = StErr;
                            w_tx_d    = 8'hFF;
                        end else if (bus.spi_rx_data[7]) begin
                            w_state_d = StWrData;
                            w_ptr_d   = w_cmd_idx[PTR_W-1:0];
                            w_tx_d    = 8'h00;
                        end else begin
                            w_state_d = StRdData;
                            w_tx_d    = r_z80_to_spi[w_cmd_idx[PTR_W-1:0]];
                            w_ptr_d   = f_next(w_cmd_idx[PTR_W-1:0]);
                        end
                    end
                end
                StWrData: begin
                    if (bus.spi_rx_valid) begin
                        w_spi_wr_en = 1'b1;
                        w_ptr_d     = f_next(r_ptr);
                    end
                end
                StRdData: begin
                    if (bus.spi_rx_valid) begin
                        w_tx_d  = r_z80_to_spi[r_ptr];
                        w_ptr_d = f_next(r_ptr);
                    end
                end
                StErr: begin
                    w_tx_d = 8'hFF;
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    // SPI frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_ptr   <= '0;
            r_tx    <= 8'h00;
        end else begin
            r_state <= w_state_d;
            r_ptr   <= w_ptr_d;
            r_tx    <= w_tx_d;
        end
    end

    assign bus.spi_tx_data = r_tx;

    // SPI-side writes into the SPI->Z80 mailboxes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_spi_to_z80[i] <= 8'h00;
            end
        end else if (w_spi_wr_en) begin
            r_spi_to_z80[r_ptr] <= bus.spi_rx_data;
        end
    end

endmodule

// File: tb/tb_z80_spi_mailbox.sv
// Self-checking bench for z80_spi_mailbox: directed sequences, a decode table
// and randomized Z80/SPI traffic against a transaction-level model.
module tb_z80_spi_mailbox;

    localparam int unsigned N      = 8;
    localparam logic [15:0] BASE   = 16'd12345;
    localparam int unsigned STRIDE = 2;
    localparam int unsigned S      = 2;
    localparam logic [15:0] STATUS_A = 16'(32'(BASE) + N * STRIDE);
    localparam logic [15:0] CTRL_A   = 16'(32'(STATUS_A) + STRIDE);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tb_d_en = 1'b0;
    logic [7:0] tb_d = 8'h00;
    wire  [7:0] z80_d;

    assign z80_d = tb_d_en ? tb_d : 8'bz;

    z80_spi_mailbox_if bus_if ();

    z80_spi_mailbox #(
        .NUM_REGS    (N),
        .BASE_ADDR   (BASE),
        .ADDR_STRIDE (STRIDE),
        .SYNC_STAGES (S)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .z80_d (z80_d),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [7:0] m_s2z [N];
    logic [7:0] m_z2s [N];
    logic [7:0] m_flags;
    logic       m_irq;
    logic [7:0] fr_buf [16];

    typedef struct {
        logic [15:0] a;
        logic        iorq;
        logic        mreq;
        logic        m1;
        logic        rd;
        logic        wr;
        logic        exp_dir;
        logic [7:0]  exp_d;
    } dec_vec_t;

    dec_vec_t vecs [12];

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic int mb_of(input logic [15:0] a);
        for (int i = 0; i < N; i++) begin
            if (a == 16'(32'(BASE) + i * STRIDE)) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] int_n_exp();
        return {7'b0, ~(m_irq & (m_flags != 8'h00))};
    endfunction

    task automatic check_int(input string name);
        check8(name, {7'b0, bus_if.z80_int_n}, int_n_exp());
    endtask

    // One Z80 bus cycle held long enough for the synchroniser; starts/ends 1ns after an edge.
    task automatic z80_cycle(input logic [15:0] a, input logic iorq, input logic mreq,
                             input logic m1, input logic rd, input logic wr,
                             input logic [7:0] wd, output logic [7:0] d, output logic dir);
        bus_if.z80_a    = a;
        bus_if.z80_iorq = iorq;
        bus_if.z80_mreq = mreq;
        bus_if.z80_m1   = m1;
        bus_if.z80_rd   = rd;
        bus_if.z80_wr   = wr;
        tb_d            = wd;
        tb_d_en         = ~wr;
        #1;
        d   = z80_d;
        dir = bus_if.z80_d_dir;
        repeat (S + 3) @(posedge clk);
        #1;
        bus_if.z80_iorq = 1'b1;
        bus_if.z80_rd   = 1'b1;
        bus_if.z80_wr   = 1'b1;
        bus_if.z80_mreq = 1'b1;
        bus_if.z80_m1   = 1'b1;
        tb_d_en         = 1'b0;
        repeat (S + 2) @(posedge clk);
        #1;
        // Model effect of a decoded read or write.
        if (!iorq && mreq && m1) begin
            if (!rd && wr && mb_of(a) >= 0) m_flags[mb_of(a)] = 1'b0;
            if (rd && !wr) begin
                if (mb_of(a) >= 0) m_z2s[mb_of(a)] = wd;
                else if (a == CTRL_A) m_irq = wd[0];
            end
        end
    endtask

    task automatic z80_read_chk(input string name, input logic [15:0] a);
        logic [7:0] d;
        logic       dir;
        logic [7:0] exp;
        logic       exp_dir;
        exp_dir = 1'b0;
        exp     = 8'h00;
        if (mb_of(a) >= 0) exp = m_s2z[mb_of(a)];
        else if (a == STATUS_A) exp = m_flags;
        else if (a == CTRL_A) exp = {7'b0, m_irq};
        else exp_dir = 1'b1;
        z80_cycle(a, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, d, dir);
        check8({name, "_dir"}, {7'b0, dir}, {7'b0, exp_dir});
        if (!exp_dir) check8(name, d, exp);
    endtask

    task automatic z80_write(input logic [15:0] a, input logic [7:0] wd);
        logic [7:0] d;
        logic       dir;
        z80_cycle(a, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, wd, d, dir);
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] tx);
        bus_if.spi_rx_data  = b;
        bus_if.spi_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.spi_rx_valid = 1'b0;
        tx = bus_if.spi_tx_data;
        @(posedge clk);
        #1;
    endtask

    // Full SPI frame: cmd then len bytes from fr_buf, checked against the model.
    task automatic spi_frame(input logic [7:0] cmd, input int len);
        logic [7:0] tx;
        int         idx;
        bus_if.spi_cs_n = 1'b0;
        @(posedge clk);
        #1;
        check8("frame_status", bus_if.spi_tx_data, m_flags);
        spi_byte(cmd, tx);
        idx = int'(cmd[6:0]);
        if (idx >= N) begin
            check8("err_cmd_tx", tx, 8'hFF);
            for (int k = 0; k < len; k++) begin
                spi_byte(fr_buf[k], tx);
                check8("err_data_tx", tx, 8'hFF);
            end
        end else if (cmd[7]) begin
            check8("wr_cmd_tx", tx, 8'h00);
            for (int k = 0; k < len; k++) begin
                spi_byte(fr_buf[k], tx);
                m_s2z[(idx + k) % N]   = fr_buf[k];
                m_flags[(idx + k) % N] = 1'b1;
            end
        end else begin
            check8("rd_cmd_tx", tx, m_z2s[idx]);
            for (int k = 1; k <= len; k++) begin
                spi_byte(fr_buf[k-1], tx);
                check8("rd_data_tx", tx, m_z2s[(idx + k) % N]);
            end
        end
        bus_if.spi_cs_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  d;
        logic        dir;
        logic [7:0]  tx;
        logic [15:0] a;
        int          op;
        int          sel;

        bus_if.z80_a        = 16'h0000;
        bus_if.z80_rd       = 1'b1;
        bus_if.z80_wr       = 1'b1;
        bus_if.z80_iorq     = 1'b1;
        bus_if.z80_mreq     = 1'b1;
        bus_if.z80_m1       = 1'b1;
        bus_if.spi_cs_n     = 1'b1;
        bus_if.spi_rx_valid = 1'b0;
        bus_if.spi_rx_data  = 8'h00;
        for (int i = 0; i < N; i++) begin
            m_s2z[i] = 8'h00;
            m_z2s[i] = 8'h00;
        end
        m_flags = 8'h00;
        m_irq   = 1'b0;

        // Reset and idle state.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check8("rst_int_n", {7'b0, bus_if.z80_int_n}, 8'h01);
        check8("rst_dir", {7'b0, bus_if.z80_d_dir}, 8'h01);
        check8("rst_tx", bus_if.spi_tx_data, 8'h00);
        z80_read_chk("rst_status", STATUS_A);

        // SPI write frame starting at mailbox 2.
        fr_buf[0] = 8'hA5;
        fr_buf[1] = 8'h5A;
        spi_frame(8'h82, 2);
        check8("wr_flags_model", m_flags, 8'h0C);
        z80_read_chk("status_0c", STATUS_A);
        z80_read_chk("mb2_a5", 16'(32'(BASE) + 2 * STRIDE));
        z80_read_chk("status_08", STATUS_A);

        // IRQ enable, then timed clear of the last flag.
        z80_write(CTRL_A, 8'h01);
        check8("irq_on_int_n", {7'b0, bus_if.z80_int_n}, 8'h00);
        bus_if.z80_a    = 16'(32'(BASE) + 3 * STRIDE);
        bus_if.z80_iorq = 1'b0;
        bus_if.z80_rd   = 1'b0;
        #1;
        check8("mb3_5a", z80_d, 8'h5A);
        repeat (S + 1) @(posedge clk);
        #1;
        check8("int_n_at_clear", {7'b0, bus_if.z80_int_n}, 8'h00);
        @(posedge clk);
        #1;
        check8("int_n_after_clear", {7'b0, bus_if.z80_int_n}, 8'h01);
        bus_if.z80_iorq = 1'b1;
        bus_if.z80_rd   = 1'b1;
        m_flags[3]      = 1'b0;
        repeat (S + 2) @(posedge clk);
        #1;

        // Read frame wrapping from mailbox 7 to 0.
        z80_write(16'(32'(BASE) + 7 * STRIDE), 8'h11);
        z80_write(BASE, 8'h77);
        fr_buf[0] = 8'h00;
        fr_buf[1] = 8'h00;
        spi_frame(8'h07, 2);

        // Error frame, then a normal frame must start with status.
        fr_buf[0] = 8'h33;
        fr_buf[1] = 8'h44;
        fr_buf[2] = 8'h55;
        spi_frame(8'h09, 3);
        spi_frame(8'h00, 0);
        z80_read_chk("err_status", STATUS_A);

        // Collision: SPI write of mailbox 1 on the cycle the Z80 read clears flag 1.
        bus_if.spi_cs_n = 1'b0;
        @(posedge clk);
        #1;
        spi_byte(8'h81, tx);
        bus_if.z80_a    = 16'(32'(BASE) + 1 * STRIDE);
        bus_if.z80_iorq = 1'b0;
        bus_if.z80_rd   = 1'b0;
        repeat (S) @(posedge clk);
        #1;
        bus_if.spi_rx_data  = 8'h3C;
        bus_if.spi_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.spi_rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus_if.z80_iorq = 1'b1;
        bus_if.z80_rd   = 1'b1;
        bus_if.spi_cs_n = 1'b1;
        m_s2z[1]   = 8'h3C;
        m_flags[1] = 1'b1;
        repeat (S + 2) @(posedge clk);
        #1;
        z80_read_chk("collision_status", STATUS_A);

        // Abort mid write frame; a byte after cs rises must not commit.
        bus_if.spi_cs_n = 1'b0;
        @(posedge clk);
        #1;
        spi_byte(8'h84, tx);
        spi_byte(8'hC3, tx);
        bus_if.spi_cs_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        spi_byte(8'hEE, tx);
        m_s2z[4]   = 8'hC3;
        m_flags[4] = 1'b1;
        z80_read_chk("abort_mb5", 16'(32'(BASE) + 5 * STRIDE));
        z80_read_chk("abort_mb4", 16'(32'(BASE) + 4 * STRIDE));

        // Decode table after loading all mailboxes (all flags set).
        for (int i = 0; i < N; i++) fr_buf[i] = 8'(8'h10 + 8'h11 * i);
        spi_frame(8'h80, N);
        vecs[0]  = '{BASE,          1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10};
        vecs[1]  = '{16'd12359,     1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h87};
        vecs[2]  = '{BASE,          1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
        vecs[3]  = '{BASE,          1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};
        vecs[4]  = '{BASE,          1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
        vecs[5]  = '{BASE,          1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[6]  = '{16'd12346,     1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
        vecs[7]  = '{16'd12361,     1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h7E};
        vecs[8]  = '{16'd12363,     1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01};
        vecs[9]  = '{16'd12364,     1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
        vecs[10] = '{16'd12344,     1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
        vecs[11] = '{16'd12351,     1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h43};
        for (int v = 0; v < 12; v++) begin
            z80_cycle(vecs[v].a, vecs[v].iorq, vecs[v].mreq, vecs[v].m1, vecs[v].rd,
                      vecs[v].wr, 8'h00, d, dir);
            check8($sformatf("vec%0d_dir", v), {7'b0, dir}, {7'b0, vecs[v].exp_dir});
            if (!vecs[v].exp_dir) check8($sformatf("vec%0d_data", v), d, vecs[v].exp_d);
        end
        z80_read_chk("vec_status_after", STATUS_A);

        // Randomized traffic against the model.
        for (int it = 0; it < 60; it++) begin
            op  = int'($urandom_range(0, 2));
            sel = int'($urandom_range(0, N - 1));
            if (op == 0) begin
                case ($urandom_range(0, 3))
                    0: a = 16'(32'(BASE) + sel * STRIDE);
                    1: a = CTRL_A;
                    2: a = STATUS_A;
                    default: a = 16'(32'(BASE) + sel * STRIDE + 1);
                endcase
                z80_write(a, 8'($urandom));
            end else if (op == 1) begin
                case ($urandom_range(0, 3))
                    0: a = 16'(32'(BASE) + sel * STRIDE);
                    1: a = CTRL_A;
                    2: a = STATUS_A;
                    default: a = 16'(32'(BASE) + sel * STRIDE + 1);
                endcase
                z80_read_chk("rnd_read", a);
            end else begin
                for (int k = 0; k < 16; k++) fr_buf[k] = 8'($urandom);
                spi_frame({1'($urandom), 7'($urandom_range(0, N + 1))},
                          int'($urandom_range(0, 6)));
            end
            check_int("rnd_int_n");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
